// File: rtl/double_to_sig16b.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : double_to_sig16b                                              |
// | Purpose  : Converts an IEEE-754 binary64 value into a saturated, rounded |
// |            (half away from zero) signed 16-bit sample, registered once   |
// |            per sampling period when enabled.                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module double_to_sig16b (
  input  logic        clk_operation,
  input  logic        rst,
  input  logic        enable,
  input  logic [12:0] sampling_cycle_counter,
  input  logic [63:0] double,
  output logic [15:0] sig16b
);

  // Biased exponent thresholds for the magnitude decode.
  localparam logic [10:0] C_EXP_HALF  = 11'd1022; // E = -1
  localparam logic [10:0] C_EXP_MAX16 = 11'd1038; // E = 15
  localparam logic [10:0] C_EXP_SPEC  = 11'd2047; // inf / NaN
  // Round-bit position is 51-E = 1074-e; for e in 1023..1038 this equals
  // (50 - e[5:0]) mod 64, so only the low exponent bits are needed.
  localparam logic [5:0]  C_SHIFT_OFS = 6'd50;

  logic        w_sign;
  logic [10:0] w_exp;
  logic [51:0] w_frac;
  logic [52:0] w_mant;
  logic [5:0]  w_shift;
  logic [52:0] w_shifted;
  logic [52:0] w_mag;
  logic [15:0] w_result;
  logic        w_update;
  logic [15:0] sig16b_q;
  logic [15:0] sig16b_d;

  assign w_sign    = double[63];
  assign w_exp     = double[62:52];
  assign w_frac    = double[51:0];
  assign w_mant    = {1'b1, w_frac};
  assign w_shift   = C_SHIFT_OFS - w_exp[5:0];
  // Keeps the round bit as bit 0; integer part sits above it.
  assign w_shifted = w_mant >> w_shift;

  // Rounded magnitude; out-of-range exponents are forced above 32768.
  always_comb begin
    w_mag = '0;
    if (w_exp < C_EXP_HALF) begin
      w_mag = '0;
    end else if (w_exp == C_EXP_HALF) begin
      w_mag = 53'd1;
    end else if (w_exp <= C_EXP_MAX16) begin
      w_mag = {1'b0, w_shifted[52:1]} + {52'd0, w_shifted[0]};
    end else begin
      w_mag = 53'h10000;
    end
  end

  // Special-value handling, saturation and sign application.
  always_comb begin
    w_result = 16'h0000;
    if (w_exp == 11'd0) begin
      w_result = 16'h0000;
    end else if (w_exp == C_EXP_SPEC) begin
      if (w_frac != 52'd0) begin
        w_result = 16'h0000;
      end else begin
        w_result = w_sign ? 16'h8000 : 16'h7FFF;
      end
    end else if (!w_sign && (w_mag > 53'd32767)) begin
      w_result = 16'h7FFF;
    end else if (w_sign && (w_mag > 53'd32768)) begin
      w_result = 16'h8000;
    end else if (w_sign) begin
      // A zero magnitude negates to zero, so -0 never yields 0x8000.
      w_result = ~w_mag[15:0] + 16'd1;
    end else begin
      w_result = w_mag[15:0];
    end
  end

  assign w_update = enable && (sampling_cycle_counter == 13'd0);

  // Next output value: new sample on the period boundary, otherwise hold.
  always_comb begin
    sig16b_d = sig16b_q;
    if (w_update) begin
      sig16b_d = w_result;
    end
  end

  // Output register with synchronous reset taking priority.
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      sig16b_q <= 16'h0000;
    end else begin
      sig16b_q <= sig16b_d;
    end
  end

  assign sig16b = sig16b_q;

endmodule
`default_nettype wire

// File: tb/tb_double_to_sig16b.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_double_to_sig16b                                           |
// | Purpose  : Directed self-checking bench for double_to_sig16b.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_double_to_sig16b;

  logic        clk_operation;
  logic        rst;
  logic        enable;
  logic [12:0] sampling_cycle_counter;
  logic [63:0] double;
  logic [15:0] sig16b;

  int checks;
  int errors;

  double_to_sig16b dut (
    .clk_operation          (clk_operation),
    .rst                    (rst),
    .enable                 (enable),
    .sampling_cycle_counter (sampling_cycle_counter),
    .double                 (double),
    .sig16b                 (sig16b)
  );

  // Free-running 100 MHz clock.
  initial clk_operation = 1'b0;
  always #5 clk_operation = ~clk_operation;

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic step(input logic r, input logic [63:0] d, input logic en,
                      input logic [12:0] cnt);
    @(negedge clk_operation);
    rst                    = r;
    double                 = d;
    enable                 = en;
    sampling_cycle_counter = cnt;
    @(posedge clk_operation);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] exp_val);
    checks++;
    assert (sig16b === exp_val)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, sig16b, exp_val);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    enable = 1'b0;
    sampling_cycle_counter = 13'd0;
    double = 64'd0;

    // Reset state, and reset priority over a qualifying update.
    step(1'b1, 64'h0, 1'b0, 13'd0);
    check("reset", 16'h0000);
    step(1'b1, 64'h3FF0000000000000, 1'b1, 13'd0);
    check("reset_priority", 16'h0000);

    // Basic values.
    step(1'b0, 64'h3FF0000000000000, 1'b1, 13'd0); check("one", 16'h0001);
    step(1'b0, 64'h408F400000000000, 1'b1, 13'd0); check("1000", 16'h03E8);
    step(1'b0, 64'hC004000000000000, 1'b1, 13'd0); check("neg2p5", 16'hFFFD);
    step(1'b0, 64'hC08F400000000000, 1'b1, 13'd0); check("neg1000", 16'hFC18);
    step(1'b0, 64'h3FF8000000000000, 1'b1, 13'd0); check("1p5", 16'h0002);

    // Rounding boundaries.
    step(1'b0, 64'h3FD999999999999A, 1'b1, 13'd0); check("0p4", 16'h0000);
    step(1'b0, 64'h3FE0000000000000, 1'b1, 13'd0); check("0p5", 16'h0001);
    step(1'b0, 64'hBFE0000000000000, 1'b1, 13'd0); check("neg0p5", 16'hFFFF);
    step(1'b0, 64'h8000000000000000, 1'b1, 13'd0); check("neg_zero", 16'h0000);
    step(1'b0, 64'h0000000000000001, 1'b1, 13'd0); check("subnormal", 16'h0000);

    // Saturation and specials.
    step(1'b0, 64'h40E3880000000000, 1'b1, 13'd0); check("40000", 16'h7FFF);
    step(1'b0, 64'hC0E0000000000000, 1'b1, 13'd0); check("neg32768", 16'h8000);
    step(1'b0, 64'hC0E0001000000000, 1'b1, 13'd0); check("neg32768p5", 16'h8000);
    step(1'b0, 64'h40DFFFE000000000, 1'b1, 13'd0); check("32767p5", 16'h7FFF);
    step(1'b0, 64'h40DFFFC000000000, 1'b1, 13'd0); check("32767", 16'h7FFF);
    step(1'b0, 64'h7FF0000000000000, 1'b1, 13'd0); check("pos_inf", 16'h7FFF);
    step(1'b0, 64'hFFF0000000000000, 1'b1, 13'd0); check("neg_inf", 16'h8000);
    step(1'b0, 64'h7FF8000000000000, 1'b1, 13'd0); check("nan", 16'h0000);

    // Gating by counter and by enable.
    step(1'b0, 64'h3FF0000000000000, 1'b1, 13'd0); check("gate_load", 16'h0001);
    step(1'b0, 64'h408F400000000000, 1'b1, 13'd5); check("gate_cnt5", 16'h0001);
    step(1'b0, 64'h408F400000000000, 1'b1, 13'd4096); check("gate_cnt4096", 16'h0001);
    step(1'b0, 64'h408F400000000000, 1'b1, 13'd0); check("gate_release", 16'h03E8);
    step(1'b0, 64'h3FF0000000000000, 1'b0, 13'd0); check("gate_en0", 16'h03E8);
    step(1'b0, 64'hC004000000000000, 1'b0, 13'd3); check("gate_en0_cnt", 16'h03E8);
    step(1'b0, 64'h3FF0000000000000, 1'b1, 13'd0); check("gate_en1", 16'h0001);

    // Reset mid-operation, then recovery on the next qualifying edge.
    step(1'b0, 64'h408F400000000000, 1'b1, 13'd0); check("pre_reset", 16'h03E8);
    step(1'b1, 64'h408F400000000000, 1'b1, 13'd0); check("mid_reset", 16'h0000);
    step(1'b0, 64'h3FF0000000000000, 1'b1, 13'd7); check("post_reset_hold", 16'h0000);
    step(1'b0, 64'h3FF0000000000000, 1'b1, 13'd0); check("post_reset_load", 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/double_to_sig16b.md
DOUBLE_TO_SIG16B -- requirements
Module: double_to_sig16b

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have these ports:
- clk_operation  input  1: operation clock; all state changes on its rising edge.
- rst  input  1: synchronous, active-high reset.
- enable  input  1: conversion/update enable, level-sensitive.
- sampling_cycle_counter  input  13: position inside the current sampling period; 0 marks the sample boundary.
- double  input  64: IEEE-754 binary64 value to convert.
- sig16b  output  16: registered two's-complement signed 16-bit result.
REQ-003 Reset SHALL be rst, synchronous and active-high, with clock clk_operation.

Function
REQ-004 sig16b SHALL update only on a rising edge where rst=0, enable=1 and sampling_cycle_counter=0; on every other edge it SHALL hold its value.
REQ-005 On an update edge, sig16b SHALL take convert(double) using the double value present at that edge.
- Latency: 1 clock.
- No handshake and no ready output.
REQ-006 convert() SHALL decode the input fields:
- sign s = bit 63.
- exponent e = bits 62:52.
- fraction f = bits 51:0.
- unbiased exponent E = e - 1023.
- mantissa m = {1, f} (53 bits).
REQ-007 If e=0 (zero or subnormal), the result SHALL be 0x0000 for either sign.
REQ-008 If e=2047 and f≠0 (NaN), the result SHALL be 0x0000.
REQ-009 If e=2047 and f=0 (infinity), the result SHALL be 0x7FFF for s=0 and 0x8000 for s=1.
REQ-010 If E<-1 (magnitude < 0.5), the rounded magnitude M SHALL be 0.
REQ-011 If E=-1 (0.5 <= magnitude < 1), M SHALL be 1.
REQ-012 For 0 <= E <= 15, M SHALL be computed as:
- integer part = m >> (52-E).
- round bit = bit (51-E) of m.
- M = integer part + round bit, i.e. round half away from zero, lower bits ignored.
- M SHALL be held in at least 17 bits.
REQ-013 If E>15, M SHALL be treated as saturating (larger than 32768).
REQ-014 Saturation SHALL be applied as follows:
- s=0 and M>32767: result 0x7FFF.
- s=1 and M>32768: result 0x8000.
- otherwise: result = +M or -M (two's complement), truncated to 16 bits.
REQ-015 Negative zero and any input with M=0 SHALL give 0x0000, never 0x8000.
REQ-016 The conversion datapath SHALL be combinational ahead of the single sig16b register; no multi-cycle FSM.
REQ-017 An enable deassertion, or any nonzero counter value, between update edges SHALL have no effect on sig16b.
REQ-018 Changes of double between update edges SHALL NOT change sig16b.

Reset
REQ-019 On a rising edge with rst=1, sig16b SHALL become 0x0000.
REQ-020 rst SHALL take priority over enable and counter.
REQ-021 Reset asserted mid-operation SHALL discard the pending value, with no recovery state.
REQ-022 After rst deasserts, the first update SHALL occur at the next edge with enable=1 and counter=0.

Verification
REQ-023 The bench SHALL cover these directed scenarios (each with enable=1, counter=0 unless stated):
- Basic values: double 0x3FF0000000000000 (1.0) -> 0x0001; 0x408F400000000000 (1000.0) -> 0x03E8; 0xC004000000000000 (-2.5) -> 0xFFFD (-3).
- Rounding boundaries: 0x3FD999999999999A (0.4) -> 0x0000; 0x3FE0000000000000 (0.5) -> 0x0001; 0xBFE0000000000000 (-0.5) -> 0xFFFF; 0x8000000000000000 (-0.0) -> 0x0000.
- Saturation and specials: 0x40E3880000000000 (40000.0) -> 0x7FFF; 0xC0E0000000000000 (-32768.0) -> 0x8000; 0x40DFFFE000000000 (32767.5) -> 0x7FFF; 0x7FF0000000000000 (+inf) -> 0x7FFF; 0x7FF8000000000000 (NaN) -> 0x0000.
- Gating: load 1.0 at counter=0, then apply 1000.0 with counter=5 and enable=1 -> sig16b stays 0x0001 until the next counter=0 edge, then 0x03E8; the same hold applies with enable=0 at counter=0.
- Reset: sig16b=0x03E8, assert rst for one edge while enable=1 and counter=0 -> 0x0000 on that edge; the next qualifying edge with 1.0 -> 0x0001.
